// File: rtl/seg_display_arbiter.sv
// Seven-segment display arbiter: shows score or timer as a background value and lets a
// requester take the display over for a fixed hold time, optionally blinking the message.
// All outputs are registered; values above 9999 are clamped so four digits always suffice.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  input  logic [15:0] timer,
  input  logic        timer_active,
  input  logic        msg_req,
  input  logic [15:0] msg_value,
  input  logic        msg_blink,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [15:0] disp_value,
  output logic        disp_blank,
  output logic [1:0]  sel
);

  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES) + 1;

  localparam logic [15:0] MaxDisp = 16'd9999;

  localparam logic [1:0] SelScore = 2'd0;
  localparam logic [1:0] SelTimer = 2'd1;
  localparam logic [1:0] SelMsg   = 2'd2;

  typedef enum logic [0:0] {
    StShowBg,
    StShowMsg
  } state_e;

  state_e state_q, state_d;

  // Latched message and counters
  logic [15:0]       msg_val_q, msg_val_d;
  logic              msg_blink_q, msg_blink_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_off_q, phase_off_d;

  // Registered outputs
  logic [15:0] disp_value_q, disp_value_d;
  logic [1:0]  sel_q, sel_d;
  logic        disp_blank_q, disp_blank_d;
  logic        msg_ack_q, msg_ack_d;
  logic        msg_busy_q, msg_busy_d;

  logic        accept;
  logic        hold_last;
  logic [15:0] bg_value;
  logic [1:0]  bg_sel;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    return (v > MaxDisp) ? MaxDisp : v;
  endfunction

  // A message can only be taken while the background owns the display
  assign accept    = (state_q == StShowBg) && msg_req;
  // hold_cnt_q numbers the message cycle currently on the display (1..HOLD_CYCLES)
  assign hold_last = (hold_cnt_q == HoldW'(HOLD_CYCLES));
  assign bg_value  = timer_active ? timer : score;
  assign bg_sel    = timer_active ? SelTimer : SelScore;

  // State register and all datapath/output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StShowBg;
      msg_val_q    <= '0;
      msg_blink_q  <= 1'b0;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      phase_off_q  <= 1'b0;
      disp_value_q <= '0;
      sel_q        <= SelScore;
      disp_blank_q <= 1'b0;
      msg_ack_q    <= 1'b0;
      msg_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_val_q    <= msg_val_d;
      msg_blink_q  <= msg_blink_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_off_q  <= phase_off_d;
      disp_value_q <= disp_value_d;
      sel_q        <= sel_d;
      disp_blank_q <= disp_blank_d;
      msg_ack_q    <= msg_ack_d;
      msg_busy_q   <= msg_busy_d;
    end
  end

  // Next-state: take a message when requested, give the display back after the hold time
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StShowBg:  if (msg_req)   state_d = StShowMsg;
      StShowMsg: if (hold_last) state_d = StShowBg;
      default:   state_d = StShowBg;
    endcase
  end

  // Output and counter next values
  always_comb begin
    msg_val_d    = msg_val_q;
    msg_blink_d  = msg_blink_q;
    hold_cnt_d   = hold_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    phase_off_d  = phase_off_q;
    disp_value_d = clamp(bg_value);
    sel_d        = bg_sel;
    disp_blank_d = 1'b0;
    msg_ack_d    = 1'b0;
    msg_busy_d   = 1'b0;

    if (accept) begin
      // First message cycle starts now with the blink phase visible
      msg_val_d    = clamp(msg_value);
      msg_blink_d  = msg_blink;
      hold_cnt_d   = HoldW'(1);
      blink_cnt_d  = BlinkW'(1);
      phase_off_d  = 1'b0;
      disp_value_d = clamp(msg_value);
      sel_d        = SelMsg;
      msg_ack_d    = 1'b1;
      msg_busy_d   = 1'b1;
    end else if (state_q == StShowMsg) begin
      if (hold_last) begin
        // Background values were already selected by the defaults
        hold_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_off_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q + HoldW'(1);
        // Counter reloads instead of wrapping; phase flips every BLINK_CYCLES cycles
        if (blink_cnt_q == BlinkW'(BLINK_CYCLES)) begin
          blink_cnt_d = BlinkW'(1);
          phase_off_d = ~phase_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
        disp_value_d = msg_val_q;
        sel_d        = SelMsg;
        msg_busy_d   = 1'b1;
        disp_blank_d = msg_blink_q & phase_off_d;
      end
    end
  end

  assign disp_value = disp_value_q;
  assign sel        = sel_q;
  assign disp_blank = disp_blank_q;
  assign msg_ack    = msg_ack_q;
  assign msg_busy   = msg_busy_q;

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles a message stays on the display (1 s at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 12_500_000, half-period of message blink in cycles.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port score  input  16  background value (binary).
REQ-006 SHALL have port timer  input  16  countdown value (binary).
REQ-007 SHALL have port timer_active  input  1  high: timer replaces score as background.
REQ-008 SHALL have port msg_req  input  1  message request, held high until msg_ack.
REQ-009 SHALL have port msg_value  input  16  message value, sampled at acceptance.
REQ-010 SHALL have port msg_blink  input  1  message blinks if high, sampled at acceptance.
REQ-011 SHALL have port msg_ack  output  1  one-cycle acceptance pulse.
REQ-012 SHALL have port msg_busy  output  1  high while a message owns the display.
REQ-013 SHALL have port disp_value  output  16  registered value for four_digit_seg, range 0..9999.
REQ-014 SHALL have port disp_blank  output  1  high: display must be blanked (blink off-phase).
REQ-015 SHALL have port sel  output  2  current source: 0 score, 1 timer, 2 message.

Function
REQ-016 SHALL implement states SHOW_BG and SHOW_MSG; all outputs registered.
REQ-017 In SHOW_BG, sel and disp_value SHALL follow timer (sel=1) if timer_active else score (sel=0), with one-cycle latency.
REQ-018 Any source value >9999 SHALL be clamped to 9999 before driving disp_value.
REQ-019 In SHOW_BG with msg_req=1 at an edge T: latch msg_value/msg_blink, go SHOW_MSG, msg_ack=1 and msg_busy=1 for the cycle after T.
REQ-020 msg_ack SHALL be high exactly one cycle per accepted message; never asserted in SHOW_MSG.
REQ-021 In SHOW_MSG, disp_value SHALL equal the latched (clamped) message, sel=2, ignoring score/timer/msg_value changes.
REQ-022 Message SHALL be displayed exactly HOLD_CYCLES cycles (cycles T+1..T+HOLD_CYCLES); at edge T+HOLD_CYCLES return to SHOW_BG, msg_busy=0.
REQ-023 msg_req high during SHOW_MSG SHALL stay pending (no ack); acceptance occurs at the first SHOW_BG edge, so background shows at least one cycle between messages.
REQ-024 msg_req and timer_active rising together SHALL give priority to the message.
REQ-025 Blink phase counter SHALL restart at acceptance with phase visible; phase toggles every BLINK_CYCLES cycles.
REQ-026 disp_blank SHALL be 1 only in SHOW_MSG with latched blink=1 and phase off; else 0.
REQ-027 Hold and blink counters SHALL be sized $clog2(param)+1 and SHALL NOT wrap while in SHOW_MSG.
REQ-028 msg_req dropped before ack SHALL cancel the request with no side effects.

Reset
REQ-029 rst=1 SHALL immediately force SHOW_BG, disp_value=0, sel=0, disp_blank=0, msg_ack=0, msg_busy=0, all counters 0, latched message 0.
REQ-030 rst asserted mid-message SHALL abort it; after release, a still-high msg_req SHALL be accepted as new.
REQ-031 First post-reset edge SHALL load the background value.

Verification (HOLD_CYCLES=8, BLINK_CYCLES=2)
REQ-032 score=1234, timer_active=0 -> disp_value=1234, sel=0 next cycle; timer=59, timer_active=1 -> disp_value=59, sel=1.
REQ-033 score=12000 -> disp_value=9999.
REQ-034 msg_req=1, msg_value=42, blink=0 -> one msg_ack pulse; disp_value=42, sel=2 exactly 8 cycles; then background, msg_busy=0.
REQ-035 msg_blink=1 -> disp_blank pattern 0,0,1,1,0,0,1,1 across the 8 message cycles, 0 afterwards.
REQ-036 second msg_req held during first message -> no ack until return; one background cycle, then ack and new value.
REQ-037 rst pulse at message cycle 3 -> outputs zero asynchronously; post-release background shown, held msg_req re-acked.
